// File: rtl/mul_share_arb_pkg.sv
// Shared widths and FSM encoding for the multiplier-sharing arbiter.
package mul_share_arb_pkg;

  localparam int W_DEF = 64;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/mul_share_arb_rr_arb.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
// Zero latency; grant is all-zero when no request is set.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[wrap_idx(int'(ptr), k)]) begin
        found                       = 1'b1;
        gnt[wrap_idx(int'(ptr), k)] = 1'b1;
        idx                         = IW'(wrap_idx(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one pipelined multiplier among NREQ requesters; result returns MUL_LAT+1 cycles after accept.
// Requesters are backpressured via req_ready (round-robin, gated by drain); results have no backpressure.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 4,
  parameter int W       = W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*W-1:0]             req_a,
  input  logic [NREQ*W-1:0]             req_b,
  output logic [W-1:0]                  mul_a,
  output logic [W-1:0]                  mul_b,
  input  logic [prod_w(W)-1:0]          mul_p,
  output logic [NREQ-1:0]               res_valid,
  output logic [prod_w(W)-1:0]          res_p,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic [$clog2(MUL_LAT+2)-1:0]  inflight
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 2);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            arb_en;
  logic            hs;
  logic            res_any;
  logic [W-1:0]    a_sel, b_sel;
  logic [MUL_LAT:0] tag_vld;
  logic [IW-1:0]   tag_id [MUL_LAT+1];

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // drain_req gates issue in the same cycle, before the FSM leaves RUN
  assign arb_en    = (state == RUN) && !drain_req && !rst;
  assign req_ready = arb_en ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      rr_ptr   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      tag_vld  <= '0;
      inflight <= '0;
      for (int s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
    end else begin
      state     <= state_nxt;
      tag_vld   <= {tag_vld[MUL_LAT-1:0], hs};
      tag_id[0] <= gnt_idx;
      for (int s = 1; s <= MUL_LAT; s++) tag_id[s] <= tag_id[s-1];
      if (hs) begin
        mul_a  <= a_sel;
        mul_b  <= b_sel;
        rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
      if (hs && !res_any)
        inflight <= inflight + CW'(1);
      else if (!hs && res_any)
        inflight <= inflight - CW'(1);
    end
  end

  assign res_any = tag_vld[MUL_LAT];
  assign res_p   = mul_p;

  always_comb begin
    res_valid = '0;
    if (tag_vld[MUL_LAT]) res_valid[tag_id[MUL_LAT]] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)                        state_nxt = RUN;
        else if (inflight == '0 && !res_any)   state_nxt = HALTED;
      end
      HALTED:  if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Also report done in the first empty DRAIN cycle, one cycle after the last result
  assign drain_done = drain_req &&
                      ((state == HALTED) || (state == DRAIN && inflight == '0));

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a MUL_LAT-stage multiplier model.
module tb_mul_share_arb;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 4;
  localparam int W       = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_p, res_p;
  logic [NREQ-1:0]   res_valid;
  logic              drain_req;
  logic              drain_done;
  logic [2:0]        inflight;
  logic [2*W-1:0]    p_pipe [MUL_LAT];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .res_valid  (res_valid),
    .res_p      (res_p),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .inflight   (inflight)
  );

  // Multiplier stand-in: samples mul_a/mul_b every edge, product out MUL_LAT edges later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < MUL_LAT; s++) p_pipe[s] <= '0;
    end else begin
      p_pipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      for (int s = 1; s < MUL_LAT; s++) p_pipe[s] <= p_pipe[s-1];
    end
  end
  assign mul_p = p_pipe[MUL_LAT-1];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    drain_req = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL reset_res_valid: got %b want 0000", res_valid); end
    total++; if (mul_a !== 64'd0 || mul_b !== 64'd0) begin bad++; $display("FAIL reset_mul_ab: got %h/%h want 0/0", mul_a, mul_b); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done: got %b want 0", drain_done); end
    apply_reset();
    #1;
    total++; if (inflight !== 3'd0 || res_valid !== 4'b0000) begin bad++; $display("FAIL reset_release: inflight %0d res_valid %b want 0/0000", inflight, res_valid); end
  endtask

  task automatic test_single();
    set_req(2, 64'd3, 64'd5);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    set_req(2, 64'hDEAD, 64'hBEEF);
    #1;
    total++; if (mul_a !== 64'd3 || mul_b !== 64'd5) begin bad++; $display("FAIL single_mul_ab: got %0d/%0d want 3/5", mul_a, mul_b); end
    total++; if (inflight !== 3'd1) begin bad++; $display("FAIL single_inflight1: got %0d want 1", inflight); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL single_early_res: edge +%0d got %b want 0000", k, res_valid); end
    end
    tick();
    total++; if (res_valid !== 4'b0100) begin bad++; $display("FAIL single_res_valid: got %b want 0100", res_valid); end
    total++; if (res_p !== 128'd15) begin bad++; $display("FAIL single_res_p: got %0d want 15", res_p); end
    total++; if (mul_a !== 64'd3) begin bad++; $display("FAIL single_hold_a: got %h want 3", mul_a); end
    tick();
    total++; if (res_valid !== 4'b0000 || inflight !== 3'd0) begin bad++; $display("FAIL single_after: res_valid %b inflight %0d want 0000/0", res_valid, inflight); end
  endtask

  task automatic test_simultaneous();
    set_req(0, 64'd10, 64'd11);
    set_req(3, 64'd20, 64'd3);
    req_valid = 4'b1001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL simul_first: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL simul_second: got %b want 1000", req_ready); end
    total++; if (mul_a !== 64'd10) begin bad++; $display("FAIL simul_mul_a0: got %0d want 10", mul_a); end
    tick();
    req_valid = '0;
    #1;
    total++; if (mul_a !== 64'd20 || inflight !== 3'd2) begin bad++; $display("FAIL simul_issue3: mul_a %0d inflight %0d want 20/2", mul_a, inflight); end
    tick();
    tick();
    tick();
    total++; if (res_valid !== 4'b0001 || res_p !== 128'd110) begin bad++; $display("FAIL simul_res0: got %b/%0d want 0001/110", res_valid, res_p); end
    tick();
    total++; if (res_valid !== 4'b1000 || res_p !== 128'd60) begin bad++; $display("FAIL simul_res3: got %b/%0d want 1000/60", res_valid, res_p); end
    tick();
    total++; if (res_valid !== 4'b0000 || inflight !== 3'd0) begin bad++; $display("FAIL simul_after: res_valid %b inflight %0d want 0000/0", res_valid, inflight); end
  endtask

  task automatic test_all_valid();
    logic [3:0]   exp_rdy, exp_res;
    logic [127:0] exp_p;
    int           g_done, r_done;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'd7);
    req_valid = 4'hF;
    for (int t = 0; t <= 17; t++) begin
      if (t == 12) req_valid = '0;
      #1;
      exp_rdy = (t < 12) ? 4'(1 << (t % 4)) : 4'b0000;
      g_done  = (t < 12) ? t : 12;
      r_done  = (t < 5) ? 0 : ((t - 5 > 12) ? 12 : t - 5);
      exp_res = 4'b0000;
      exp_p   = '0;
      if (t >= 5 && t - 5 < 12) begin
        exp_res = 4'(1 << ((t - 5) % 4));
        exp_p   = 128'(((t - 5) % 4 + 1) * 7);
      end
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL allv_grant t=%0d: got %b want %b", t, req_ready, exp_rdy); end
      total++; if (inflight !== 3'(g_done - r_done)) begin bad++; $display("FAIL allv_inflight t=%0d: got %0d want %0d", t, inflight, g_done - r_done); end
      total++; if (res_valid !== exp_res) begin bad++; $display("FAIL allv_res_valid t=%0d: got %b want %b", t, res_valid, exp_res); end
      if (exp_res != 4'b0000) begin
        total++; if (res_p !== exp_p) begin bad++; $display("FAIL allv_res_p t=%0d: got %0d want %0d", t, res_p, exp_p); end
      end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [3:0]   exp_res;
    logic [127:0] exp_p;
    int           exp_inf;
    apply_reset();
    req_valid = 4'hF;
    repeat (3) tick();
    drain_req = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL drain_gate: got %b want 0000", req_ready); end
    total++; if (inflight !== 3'd3) begin bad++; $display("FAIL drain_inflight3: got %0d want 3", inflight); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL drain_done_early: got %b want 0", drain_done); end
    for (int e = 3; e <= 8; e++) begin
      tick();
      exp_res = (e >= 4 && e <= 6) ? 4'(1 << (e - 4)) : 4'b0000;
      exp_p   = 128'((e - 3) * 7);
      exp_inf = 3 - ((e < 4) ? 0 : ((e - 4 > 3) ? 3 : e - 4));
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL drain_ready e=%0d: got %b want 0000", e, req_ready); end
      total++; if (res_valid !== exp_res) begin bad++; $display("FAIL drain_res e=%0d: got %b want %b", e, res_valid, exp_res); end
      if (exp_res != 4'b0000) begin
        total++; if (res_p !== exp_p) begin bad++; $display("FAIL drain_res_p e=%0d: got %0d want %0d", e, res_p, exp_p); end
      end
      total++; if (inflight !== 3'(exp_inf)) begin bad++; $display("FAIL drain_inflight e=%0d: got %0d want %0d", e, inflight, exp_inf); end
      total++; if (drain_done !== (e >= 7)) begin bad++; $display("FAIL drain_done e=%0d: got %b want %b", e, drain_done, e >= 7); end
    end
    drain_req = 1'b0;
    #1;
    total++; if (drain_done !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL drain_release: done %b ready %b want 0/0000", drain_done, req_ready); end
    tick();
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL drain_resume_ptr: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    #1;
    total++; if (mul_a !== 64'd4 || inflight !== 3'd1) begin bad++; $display("FAIL drain_resume_issue: mul_a %0d inflight %0d want 4/1", mul_a, inflight); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 64'(i + 1), 64'd7);
    req_valid = 4'hF;
    repeat (4) tick();
    #1;
    total++; if (inflight !== 3'd4) begin bad++; $display("FAIL midrst_inflight4: got %0d want 4", inflight); end
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000 || res_valid !== 4'b0000) begin bad++; $display("FAIL midrst_outputs: ready %b res %b want 0000/0000", req_ready, res_valid); end
    total++; if (mul_a !== 64'd0 || mul_b !== 64'd0 || inflight !== 3'd0) begin bad++; $display("FAIL midrst_regs: %h/%h/%0d want 0/0/0", mul_a, mul_b, inflight); end
    req_valid = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL midrst_stale k=%0d: got %b want 0000", k, res_valid); end
    end
    test_single();
  endtask

  task automatic test_max();
    set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL max_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    repeat (4) tick();
    total++; if (res_valid !== 4'b0010) begin bad++; $display("FAIL max_res_valid: got %b want 0010", res_valid); end
    total++; if (res_p !== 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001) begin bad++; $display("FAIL max_res_p: got %h want 3fffffffffffffff0000000000000001", res_p); end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_all_valid();
    test_drain();
    test_reset_midflight();
    test_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
